// File: rtl/cp_s1_pkg.sv
// rtl/cp_s1_pkg.sv - shared widths and sequencer state encoding for the S1 chirp sequencer
package cp_s1_pkg;

  localparam int CHP_W = 10;
  localparam int FRM_W = 4;
  localparam int TMO_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_FWAIT = 3'd4,
    ST_ABORT = 3'd5
  } cp_seq_state_t;

endpackage

// File: rtl/cp_s1_watchdog.sv
// rtl/cp_s1_watchdog.sv - per-chirp cycle counter; a zero limit never expires
module cp_s1_watchdog #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [TMO_W-1:0] limit_i,
  output logic             expired_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign expired_o = (limit_i != '0) && (cnt_q == limit_i);

  // Holding at expiry keeps the flag stable until the sequencer reacts.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cp_s1_chirp_sequencer.sv
// rtl/cp_s1_chirp_sequencer.sv - chirp/frame sequencer driving the S1 core start/finish handshake
module cp_s1_chirp_sequencer #(
  parameter int CHP_W       = cp_s1_pkg::CHP_W,
  parameter int FRM_W       = cp_s1_pkg::FRM_W,
  parameter int ADDR_W      = 32,
  parameter int BANK_STRIDE = 1024,
  parameter int TMO_W       = cp_s1_pkg::TMO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_frame_start,
  input  logic [CHP_W-1:0]  i_chp_num,
  input  logic [FRM_W-1:0]  i_frm_num,
  input  logic [TMO_W-1:0]  i_timeout,
  input  logic              i_core_finish,
  input  logic              i_err_clr,
  output logic              o_core_start,
  output logic [ADDR_W-1:0] o_rd_base,
  output logic [ADDR_W-1:0] o_wr_base,
  output logic [CHP_W-1:0]  o_chp_idx,
  output logic [FRM_W-1:0]  o_frm_idx,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_all_done,
  output logic              o_timeout_err
);

  import cp_s1_pkg::*;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BANK_STRIDE);

  cp_seq_state_t    state_q, state_d;
  logic [CHP_W-1:0] chp_idx_q, chp_idx_d, chp_last_q, chp_last_d;
  logic [FRM_W-1:0] frm_idx_q, frm_idx_d, frm_last_q, frm_last_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             bank_q, bank_d;
  logic             frame_done_d, all_done_d, err_d;
  logic             start_q, busy_q, frame_done_q, all_done_q, err_q;
  logic [ADDR_W-1:0] rd_base_q, wr_base_q;
  logic             wd_expired;

  // Counting starts with the ARM cycle so the limit measures cycles since the start pulse.
  cp_s1_watchdog #(.TMO_W(TMO_W)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_d == ST_ARM),
    .enable_i  ((state_q == ST_ARM) || (state_q == ST_WAIT)),
    .limit_i   (tmo_q),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    chp_idx_d    = chp_idx_q;
    frm_idx_d    = frm_idx_q;
    chp_last_d   = chp_last_q;
    frm_last_d   = frm_last_q;
    tmo_d        = tmo_q;
    bank_d       = bank_q;
    frame_done_d = 1'b0;
    all_done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_enable && i_frame_start) begin
          // Stored as last index so a programmed count of 0 behaves as 1.
          chp_last_d = (i_chp_num == '0) ? '0 : i_chp_num - 1'b1;
          frm_last_d = (i_frm_num == '0) ? '0 : i_frm_num - 1'b1;
          tmo_d      = i_timeout;
          chp_idx_d  = '0;
          frm_idx_d  = '0;
          bank_d     = 1'b0;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_core_finish) begin
          state_d = ST_NEXT;
        end else if (wd_expired) begin
          state_d = ST_ABORT;
        end
      end
      ST_NEXT: begin
        bank_d = ~bank_q;
        if (chp_idx_q != chp_last_q) begin
          chp_idx_d = chp_idx_q + 1'b1;
          state_d   = i_enable ? ST_ARM : ST_IDLE;
        end else begin
          chp_idx_d    = '0;
          frame_done_d = 1'b1;
          if (frm_idx_q == frm_last_q) begin
            all_done_d = 1'b1;
            frm_idx_d  = '0;
            state_d    = ST_IDLE;
          end else begin
            frm_idx_d = frm_idx_q + 1'b1;
            state_d   = ST_FWAIT;
          end
        end
      end
      ST_FWAIT: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (i_frame_start) begin
          state_d = ST_ARM;
        end
      end
      ST_ABORT: begin
        chp_idx_d = '0;
        frm_idx_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = (state_q == ST_ABORT) || (err_q && !i_err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      chp_idx_q    <= '0;
      frm_idx_q    <= '0;
      chp_last_q   <= '0;
      frm_last_q   <= '0;
      tmo_q        <= '0;
      bank_q       <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      all_done_q   <= 1'b0;
      err_q        <= 1'b0;
      rd_base_q    <= '0;
      wr_base_q    <= STRIDE;
    end else begin
      state_q      <= state_d;
      chp_idx_q    <= chp_idx_d;
      frm_idx_q    <= frm_idx_d;
      chp_last_q   <= chp_last_d;
      frm_last_q   <= frm_last_d;
      tmo_q        <= tmo_d;
      bank_q       <= bank_d;
      start_q      <= (state_d == ST_ARM);
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= frame_done_d;
      all_done_q   <= all_done_d;
      err_q        <= err_d;
      rd_base_q    <= bank_d ? STRIDE : '0;
      wr_base_q    <= bank_d ? '0 : STRIDE;
    end
  end

  assign o_core_start  = start_q;
  assign o_rd_base     = rd_base_q;
  assign o_wr_base     = wr_base_q;
  assign o_chp_idx     = chp_idx_q;
  assign o_frm_idx     = frm_idx_q;
  assign o_busy        = busy_q;
  assign o_frame_done  = frame_done_q;
  assign o_all_done    = all_done_q;
  assign o_timeout_err = err_q;

endmodule
